// File: rtl/npu_result_streamer.sv
// AXI-stream master that requantises one row of INT32 accumulators to INT8
// (round-half-up shift plus saturation) and streams it one column per beat.
module npu_result_streamer #(
  parameter int N_COLS        = 4,
  parameter int ACC_W         = 32,
  parameter int OUT_W         = 8,
  parameter int ROWS_PER_TILE = 4,
  parameter int SHIFT_W       = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    row_valid,
  output logic                    row_ready,
  input  logic [N_COLS*ACC_W-1:0] row_data,
  input  logic [SHIFT_W-1:0]      shift,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [OUT_W-1:0]        m_tdata,
  output logic                    m_tlast,
  output logic                    busy
);

  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int RW = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(N_COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS_PER_TILE - 1);
  localparam logic signed [ACC_W:0] SAT_MAX =
    $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] SAT_MIN =
    $signed({{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

  typedef enum logic {IDLE, SEND} state_t;

  state_t                       state, state_next;
  logic [CW-1:0]                col_cnt, col_next;
  logic [RW-1:0]                row_cnt, row_next;
  logic [N_COLS-1:0][OUT_W-1:0] beat_buf;
  logic [N_COLS-1:0][OUT_W-1:0] quant;
  logic signed [ACC_W:0]        rnd;
  logic                         capture, beat_hs, last_col;

  // Rounding bias 2^(s-1); one extra bit of headroom keeps a + bias from wrapping.
  always_comb begin
    rnd = '0;
    if (shift != '0)
      rnd = {{ACC_W{1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_COLS; gi++) begin : g_col
      logic signed [ACC_W-1:0] acc;
      logic signed [ACC_W:0]   biased;
      logic signed [ACC_W:0]   shifted;
      assign acc     = row_data[gi*ACC_W +: ACC_W];
      assign biased  = $signed({acc[ACC_W-1], acc}) + rnd;
      assign shifted = biased >>> shift;
      assign quant[gi] = (shifted > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                         (shifted < SAT_MIN) ? SAT_MIN[OUT_W-1:0] :
                                               shifted[OUT_W-1:0];
    end
  endgenerate

  assign last_col = (col_cnt == LAST_COL);
  assign capture  = row_valid && row_ready;
  assign beat_hs  = m_tvalid && m_tready;

  always_comb begin
    row_ready = !rst && ((state == IDLE) || ((state == SEND) && last_col && m_tready));
    m_tvalid  = (state == SEND);
    m_tdata   = (state == SEND) ? beat_buf[col_cnt] : '0;
    m_tlast   = (state == SEND) && last_col && (row_cnt == LAST_ROW);
    busy      = (state == SEND) || (row_cnt != '0);
  end

  // A capture on the final beat overrides the return to IDLE, giving bubble-free rows.
  always_comb begin
    state_next = state;
    col_next   = col_cnt;
    row_next   = row_cnt;
    if (beat_hs) begin
      if (last_col) begin
        col_next   = '0;
        row_next   = (row_cnt == LAST_ROW) ? '0 : row_cnt + RW'(1);
        state_next = IDLE;
      end else begin
        col_next = col_cnt + CW'(1);
      end
    end
    if (capture) begin
      state_next = SEND;
      col_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      col_cnt  <= '0;
      row_cnt  <= '0;
      beat_buf <= '0;
    end else begin
      state   <= state_next;
      col_cnt <= col_next;
      row_cnt <= row_next;
      if (capture)
        beat_buf <= quant;
    end
  end

endmodule
